// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcodes, control-word bit indices and named control words.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    localparam int CP   = 12;
    localparam int EP   = 11;
    localparam int LM_N = 10;
    localparam int CE_N = 9;
    localparam int LI_N = 8;
    localparam int EI_N = 7;
    localparam int LA_N = 6;
    localparam int EA   = 5;
    localparam int SU   = 4;
    localparam int EU   = 3;
    localparam int LB_N = 2;
    localparam int LO_N = 1;

    localparam logic [6:1] T1_ONEHOT = 6'b000001;

    localparam logic [12:1] CW_IDLE   = 12'h3E3;
    localparam logic [12:1] CW_T1     = 12'h5E3;
    localparam logic [12:1] CW_T2     = 12'hBE3;
    localparam logic [12:1] CW_T3     = 12'h263;
    localparam logic [12:1] CW_LDA_T4 = 12'h1A3;
    localparam logic [12:1] CW_LDA_T5 = 12'h2C3;
    localparam logic [12:1] CW_ADD_T4 = 12'h1A3;
    localparam logic [12:1] CW_ADD_T5 = 12'h2E1;
    localparam logic [12:1] CW_ADD_T6 = 12'h3C7;
    localparam logic [12:1] CW_SUB_T4 = 12'h1AB;
    localparam logic [12:1] CW_SUB_T5 = 12'h2E9;
    localparam logic [12:1] CW_SUB_T6 = 12'h3CF;
    localparam logic [12:1] CW_OUT_T4 = 12'h3F2;

    // Number of active bus drivers in a control word (CE_bar and Ei_bar drive when low).
    function automatic logic [2:0] f_bus_drivers(input logic [12:1] cw);
        return 3'(cw[EP]) + 3'(~cw[CE_N]) + 3'(~cw[EI_N]) + 3'(cw[EA]) + 3'(cw[EU]);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: 6-bit one-hot T-state ring with freeze and synchronous reset to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_clr_bar,
    input  logic       i_freeze,
    output logic [6:1] o_t
);

    logic [6:1] r_t;

    always_ff @(posedge i_clk) begin
        if (!i_clr_bar)
            r_t <= T1_ONEHOT;
        else if (!i_freeze)
            r_t <= {r_t[5:1], r_t[6]};
    end

    assign o_t = r_t;

endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 control sequencer; combinational control word from T-state and opcode.
// Optional bus-contention checker enabled by defining SAP1_BUS_CHECK_EN.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b1
) (
    input  logic        CLK,
    input  logic        CLR_bar,
    input  logic [4:1]  OPCODE,
    output logic [6:1]  T,
    output logic [12:1] CON,
    output logic        HALTED,
    output logic        BUS_ERR
);

    logic        r_halted;
    logic        w_is_def;
    logic        w_halt_op;
    logic        w_freeze;
    logic [12:1] w_con;

    assign w_is_def  = OPCODE inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
    assign w_halt_op = (OPCODE == OP_HLT) || (!w_is_def && HALT_ON_UNDEF);
    // Freezing on the HLT edge itself keeps T parked at T4 alongside HALTED.
    assign w_freeze  = r_halted || (T[4] && w_halt_op);

    sap1_ring_counter u_ring (
        .i_clk     (CLK),
        .i_clr_bar (CLR_bar),
        .i_freeze  (w_freeze),
        .o_t       (T)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_bar)
            r_halted <= 1'b0;
        else if (T[4] && w_halt_op)
            r_halted <= 1'b1;
    end

    always_comb begin
        w_con = CW_IDLE;
        if (!r_halted) begin
            if (T[1])
                w_con = CW_T1;
            else if (T[2])
                w_con = CW_T2;
            else if (T[3])
                w_con = CW_T3;
            else begin
                case (OPCODE)
                    OP_LDA:  w_con = T[4] ? CW_LDA_T4 : T[5] ? CW_LDA_T5 : CW_IDLE;
                    OP_ADD:  w_con = T[4] ? CW_ADD_T4 : T[5] ? CW_ADD_T5 : T[6] ? CW_ADD_T6 : CW_IDLE;
                    OP_SUB:  w_con = T[4] ? CW_SUB_T4 : T[5] ? CW_SUB_T5 : T[6] ? CW_SUB_T6 : CW_IDLE;
                    OP_OUT:  w_con = T[4] ? CW_OUT_T4 : CW_IDLE;
                    default: w_con = CW_IDLE;
                endcase
            end
        end
    end

    assign CON    = w_con;
    assign HALTED = r_halted;

`ifdef SAP1_BUS_CHECK_EN
    logic r_bus_err;

    always_ff @(posedge CLK) begin
        if (!CLR_bar)
            r_bus_err <= 1'b0;
        else if (f_bus_drivers(w_con) > 3'd1)
            r_bus_err <= 1'b1;
    end

    assign BUS_ERR = r_bus_err;
`else
    assign BUS_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed scoreboard bench; two instances cover HALT_ON_UNDEF=1 and 0.
module tb_sap1_controller;

    logic        CLK = 1'b0;
    logic        CLR_bar;
    logic [4:1]  OPCODE;
    logic [6:1]  t_a, t_b;
    logic [12:1] con_a, con_b;
    logic        h_a, h_b, be_a, be_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:1]  ta;
        logic [12:1] ca;
        logic        ha;
        logic [6:1]  tb;
        logic [12:1] cb;
        logic        hb;
    } exp_t;

    exp_t q[$];

    always #5 CLK = ~CLK;

    sap1_controller #(.HALT_ON_UNDEF(1'b1)) u_halt (
        .CLK(CLK), .CLR_bar(CLR_bar), .OPCODE(OPCODE),
        .T(t_a), .CON(con_a), .HALTED(h_a), .BUS_ERR(be_a)
    );

    sap1_controller #(.HALT_ON_UNDEF(1'b0)) u_nop (
        .CLK(CLK), .CLR_bar(CLR_bar), .OPCODE(OPCODE),
        .T(t_b), .CON(con_b), .HALTED(h_b), .BUS_ERR(be_b)
    );

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push2(input logic [6:1] ta, input logic [12:1] ca, input logic ha,
                         input logic [6:1] tb, input logic [12:1] cb, input logic hb);
        q.push_back({ta, ca, ha, tb, cb, hb});
    endtask

    task automatic push(input logic [6:1] t, input logic [12:1] c, input logic h);
        push2(t, c, h, t, c, h);
    endtask

    task automatic fetch();
        push(6'h01, 12'h5E3, 1'b0);
        push(6'h02, 12'hBE3, 1'b0);
        push(6'h04, 12'h263, 1'b0);
    endtask

    // Compare the current cycle against the oldest expectation, then advance one edge.
    task automatic run();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            cmp("T_halt",      16'(t_a),   16'(e.ta));
            cmp("CON_halt",    16'(con_a), 16'(e.ca));
            cmp("HALTED_halt", 16'(h_a),   16'(e.ha));
            cmp("BUSERR_halt", 16'(be_a),  16'h0);
            cmp("T_nop",       16'(t_b),   16'(e.tb));
            cmp("CON_nop",     16'(con_b), 16'(e.cb));
            cmp("HALTED_nop",  16'(h_b),   16'(e.hb));
            cmp("BUSERR_nop",  16'(be_b),  16'h0);
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        CLR_bar = 1'b0;
        OPCODE  = 4'b0000;
        @(posedge CLK);
        #1;
        CLR_bar = 1'b1;

        // LDA
        fetch();
        push(6'h08, 12'h1A3, 1'b0);
        push(6'h10, 12'h2C3, 1'b0);
        push(6'h20, 12'h3E3, 1'b0);
        run();

        // SUB
        OPCODE = 4'b0010;
        fetch();
        push(6'h08, 12'h1AB, 1'b0);
        push(6'h10, 12'h2E9, 1'b0);
        push(6'h20, 12'h3CF, 1'b0);
        run();

        // ADD
        OPCODE = 4'b0001;
        fetch();
        push(6'h08, 12'h1A3, 1'b0);
        push(6'h10, 12'h2E1, 1'b0);
        push(6'h20, 12'h3C7, 1'b0);
        run();

        // OUT
        OPCODE = 4'b1110;
        fetch();
        push(6'h08, 12'h3F2, 1'b0);
        push(6'h10, 12'h3E3, 1'b0);
        push(6'h20, 12'h3E3, 1'b0);
        run();

        // Reset during T5 of ADD
        OPCODE = 4'b0001;
        fetch();
        push(6'h08, 12'h1A3, 1'b0);
        run();
        CLR_bar = 1'b0;
        push(6'h10, 12'h2E1, 1'b0);
        run();
        CLR_bar = 1'b1;
        fetch();
        push(6'h08, 12'h1A3, 1'b0);
        push(6'h10, 12'h2E1, 1'b0);
        push(6'h20, 12'h3C7, 1'b0);
        run();

        // HLT, then opcode churn while halted
        OPCODE = 4'b1111;
        fetch();
        push(6'h08, 12'h3E3, 1'b0);
        run();
        for (int i = 0; i < 10; i++) begin
            OPCODE = 4'($urandom_range(0, 15));
            push(6'h08, 12'h3E3, 1'b1);
            run();
        end
        CLR_bar = 1'b0;
        push(6'h08, 12'h3E3, 1'b1);
        run();
        CLR_bar = 1'b1;
        OPCODE = 4'b0000;
        push(6'h01, 12'h5E3, 1'b0);
        push(6'h02, 12'hBE3, 1'b0);
        push(6'h04, 12'h263, 1'b0);
        push(6'h08, 12'h1A3, 1'b0);
        push(6'h10, 12'h2C3, 1'b0);
        push(6'h20, 12'h3E3, 1'b0);
        run();

        // Undefined opcode: halt instance stops, nop instance carries on
        OPCODE = 4'b0101;
        fetch();
        push(6'h08, 12'h3E3, 1'b0);
        push2(6'h08, 12'h3E3, 1'b1, 6'h10, 12'h3E3, 1'b0);
        push2(6'h08, 12'h3E3, 1'b1, 6'h20, 12'h3E3, 1'b0);
        push2(6'h08, 12'h3E3, 1'b1, 6'h01, 12'h5E3, 1'b0);
        run();
        CLR_bar = 1'b0;
        push2(6'h08, 12'h3E3, 1'b1, 6'h02, 12'hBE3, 1'b0);
        run();
        CLR_bar = 1'b1;
        push(6'h01, 12'h5E3, 1'b0);
        run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 SHALL have parameter HALT_ON_UNDEF, default 1, meaning: 1 treats undefined opcodes as HLT; 0 treats them as NOP.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR_bar  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port OPCODE  input  [4:1]  instruction-register upper nibble.
REQ-005 SHALL have port T  output  [6:1]  one-hot ring-counter state; T[1]=T1 ... T[6]=T6.
REQ-006 SHALL have port CON  output  [12:1]  control word; bit map [12:1] = Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar.
REQ-007 SHALL have port HALTED  output  1  high once HLT has been executed.
REQ-008 SHALL have port BUS_ERR  output  1  sticky flag for bus-driver contention.

Function
REQ-009 SHALL advance T one-hot T1->T2->...->T6->T1 on every rising CLK edge while HALTED=0.
REQ-010 SHALL decode CON combinationally from T and OPCODE, valid in the same cycle as T; zero added latency.
REQ-011 SHALL output the inactive word 0x3E3 whenever no step action applies.
REQ-012 SHALL ignore OPCODE in T1-T3 and output fetch words there: T1 0x5E3 (Ep, Lm_bar=0), T2 0xBE3 (Cp), T3 0x263 (CE_bar=0, Li_bar=0).
REQ-013 SHALL decode opcodes LDA=0000, ADD=0001, SUB=0010, OUT=1110 and HLT=1111.
REQ-014 SHALL execute LDA as T4 0x1A3, T5 0x2C3, T6 0x3E3.
REQ-015 SHALL execute ADD as T4 0x1A3, T5 0x2E1, T6 0x3C7.
REQ-016 SHALL execute SUB as ADD with Su=1 throughout T4-T6: T4 0x1AB, T5 0x2E9, T6 0x3CF.
REQ-017 SHALL execute OUT as T4 0x3F2 (Ea, Lo_bar=0), T5 0x3E3, T6 0x3E3.
REQ-018 SHALL, in T4 with HLT, output 0x3E3, set HALTED=1 at the next edge and freeze T at T4.
REQ-019 SHALL hold HALTED=1, T frozen and CON=0x3E3 until reset, regardless of OPCODE changes.
REQ-020 SHALL handle undefined opcodes in T4 according to HALT_ON_UNDEF (REQ-001); as NOP, T4-T6 output 0x3E3 and T continues to advance.
REQ-021 SHALL never assert more than one bus driver (Ep, CE_bar=0, Ei_bar=0, Ea, Eu) in any defined step.

Reset
REQ-022 SHALL, when CLR_bar=0 at a rising edge, set T=T1 (6'b000001), HALTED=0 and BUS_ERR=0; CON therefore becomes 0x5E3.
REQ-023 SHALL give reset priority over advance and halt; reset mid-instruction or while halted aborts and restarts at T1.
REQ-024 SHALL ignore CLR_bar between clock edges (no asynchronous effect).

Configuration
REQ-025 SHALL, with SAP1_BUS_CHECK_EN defined, register BUS_ERR=1 at the edge after any cycle in which two or more bus drivers are asserted; BUS_ERR stays set until reset.
REQ-026 SHALL, without SAP1_BUS_CHECK_EN, tie BUS_ERR to 0, keep the port present and contain no checker logic.

Structure
REQ-027 SHALL place the following in shared package sap1_pkg: opcode constants, CON bit indices, and the named control words (CW_IDLE=0x3E3, CW_T1, CW_T2, CW_T3 and the execute words).
REQ-028 SHALL implement the ring counter as sub-module sap1_ring_counter: 6-bit one-hot, with freeze input and synchronous reset to T1.

Verification
REQ-029 SHALL cover: CLR_bar=0 for one edge, then release with OPCODE=0000 -> T sequence 01,02,04,08,10,20,01; CON sequence 5E3,BE3,263,1A3,2C3,3E3.
REQ-030 SHALL cover: OPCODE=0010 -> T4-T6 CON = 1AB,2E9,3CF; OPCODE=0001 -> T4-T6 CON = 1A3,2E1,3C7.
REQ-031 SHALL cover: OPCODE=1110 -> T4 CON=3F2; T5-T6 CON=3E3.
REQ-032 SHALL cover: OPCODE=1111 at T4 -> HALTED=1, T=08 and CON=3E3 for 10 further edges; then CLR_bar=0 -> T=01, HALTED=0.
REQ-033 SHALL cover: OPCODE=0101 -> HALT_ON_UNDEF=1 halts; HALT_ON_UNDEF=0 gives 3E3 in T4-T6 and continues to T1.
REQ-034 SHALL cover: CLR_bar=0 asserted during T5 of ADD -> next T=01 and CON=5E3; with SAP1_BUS_CHECK_EN defined, BUS_ERR=0 over all legal programs.
